sub_bytes: RTL and testbench

//   AES SubBytes stage: substitutes each of the 16 state bytes through the

---
 rtl/sub_bytes_if.sv | 22 ++
 rtl/sub_bytes.sv | 61 ++++++
 tb/tb_sub_bytes.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_if.sv
// Data/valid bundle for the AES SubBytes stage: the producer drives iValid/iData,
// and the stage returns oValid/oData one cycle later.
interface sub_bytes_if;
    logic         iValid;
    logic [127:0] iData;
    logic         oValid;
    logic [127:0] oData;

    modport master (
        output iValid,
        output iData,
        input  oValid,
        input  oData
    );

    modport slave (
        input  iValid,
        input  iData,
        output oValid,
        output oData
    );
endinterface

// File: rtl/sub_bytes.sv
// AES SubBytes: 16 parallel forward S-box lookups followed by one register stage.
// A new 128-bit state can be accepted every clock, and there is no backpressure.
module sub_bytes (
    input  logic        iClk,
    input  logic        iRst_n,
    sub_bytes_if.slave  bus
);

    // Forward S-box, entry 0x00 first (most significant byte of the literal).
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[8 * (255 - int'(b)) +: 8];
    endfunction

    logic         valid_d, valid_q;
    logic [127:0] data_d,  data_q;

    // oData keeps the last substituted state when no new state arrives.
    always_comb begin
        valid_d = bus.iValid;
        data_d  = data_q;
        if (bus.iValid) begin
            for (int k = 0; k < 16; k++) begin
                data_d[8*k +: 8] = sbox(bus.iData[8*k +: 8]);
            end
        end
    end

    // NOTE: registers are updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.oValid = valid_q;
    assign bus.oData  = data_q;

endmodule

// File: tb/tb_sub_bytes.sv
// Directed bench for sub_bytes: reset, FIPS-197 vectors, full-table sweep,
// valid gating, and reset in the middle of a stream.
module tb_sub_bytes;

    logic iClk;
    logic iRst_n;
    int   n_pass;
    int   n_total;

    sub_bytes_if bus ();

    sub_bytes dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference S-box, one row per high nibble and entry 0 in the leftmost byte.
    logic [127:0] sbox_rows [16];
    initial begin
        sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    end

    function automatic logic [7:0] model_sbox(input logic [7:0] v);
        logic [127:0] row;
        row = sbox_rows[v[7:4]];
        return row[8 * (15 - int'(v[3:0])) +: 8];
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic exp_valid, input logic [127:0] exp_data);
        n_total++;
        if (bus.oValid !== exp_valid || bus.oData !== exp_data)
            $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h",
                     name, bus.oValid, bus.oData, exp_valid, exp_data);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        iRst_n     = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = '0;
        #12;
        iRst_n = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 128'h112233445566778899aabbccddeeff00;
        step();
        // Assert reset between edges with a live random input.
        #3;
        bus.iData  = {$urandom, $urandom, $urandom, $urandom};
        iRst_n     = 1'b0;
        #1;
        expect_out("reset_async", 1'b0, 128'h0);
        step();
        expect_out("reset_hold_edge1", 1'b0, 128'h0);
        step();
        expect_out("reset_hold_edge2", 1'b0, 128'h0);
        #3;
        iRst_n     = 1'b1;
        bus.iValid = 1'b0;
    endtask

    task automatic test_vectors();
        bus.iValid = 1'b1;
        bus.iData  = 128'h112233445566778899aabbccddeeff00;
        step();
        expect_out("vec_ascending", 1'b1, 128'h8293c31bfc33f5c4eeacea4bc1281663);
        bus.iData  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        step();
        expect_out("vec_fips_round1", 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230);
        bus.iData  = 128'h0;
        step();
        expect_out("vec_all_zero", 1'b1, {16{8'h63}});
        bus.iData  = {16{8'hff}};
        step();
        expect_out("vec_all_ff", 1'b1, {16{8'h16}});
        bus.iData  = 128'h53000000000000000000000000000001;
        step();
        expect_out("vec_positional", 1'b1, 128'hed63636363636363636363636363637c);
        bus.iValid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v          = 8'(i);
            bus.iValid = 1'b1;
            bus.iData  = {16{v}};
            step();
            expect_out($sformatf("sweep_%02h", v), 1'b1, {16{model_sbox(v)}});
        end
        bus.iValid = 1'b0;
    endtask

    task automatic test_valid_gating();
        bus.iValid = 1'b1;
        bus.iData  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        step();
        expect_out("pulse_valid", 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230);
        bus.iValid = 1'b0;
        bus.iData  = 128'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("idle_hold_%0d", i), 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230);
        end
    endtask

    task automatic test_reset_midstream();
        bus.iValid = 1'b1;
        bus.iData  = 128'h112233445566778899aabbccddeeff00;
        step();
        expect_out("mid_before_reset", 1'b1, 128'h8293c31bfc33f5c4eeacea4bc1281663);
        #2;
        iRst_n = 1'b0;
        #1;
        expect_out("mid_reset_drop", 1'b0, 128'h0);
        #3;
        iRst_n     = 1'b1;
        bus.iData  = {16{8'h53}};
        step();
        expect_out("mid_first_after_release", 1'b1, {16{8'hed}});
        bus.iValid = 1'b0;
        step();
        expect_out("mid_idle_after_release", 1'b0, {16{8'hed}});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_valid_gating();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
